// File: rtl/alu_issue_ctrl_if.sv
// Bundle of decode-side request, ALU drive/return and response signals
// for the ALU issue controller. "master" is the controller's view,
// "slave" is the view of the decode stage, ALU and response consumer.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [15:0] in_imm;

  logic [3:0]  alu_control;
  logic [31:0] alu_operand_1;
  logic [31:0] alu_operand_2;
  logic [31:0] alu_result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_branch_taken;
  logic        rsp_overflow;
  logic        rsp_illegal;

  modport master (
    input  in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm,
    output in_ready,
    output alu_control, alu_operand_1, alu_operand_2,
    input  alu_result,
    output rsp_valid, rsp_result, rsp_branch_taken, rsp_overflow, rsp_illegal,
    input  rsp_ready
  );

  modport slave (
    output in_valid, in_opcode, in_funct, in_rs_val, in_rt_val, in_imm,
    input  in_ready,
    input  alu_control, alu_operand_1, alu_operand_2,
    output alu_result,
    input  rsp_valid, rsp_result, rsp_branch_taken, rsp_overflow, rsp_illegal,
    output rsp_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller for the multi-cycle MIPS datapath: decodes one
// instruction per handshake into an ALU control code, holds operands on the
// combinational ALU for WAIT_CYCLES, captures the result and returns it with
// branch / overflow / illegal flags.
module alu_issue_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  alu_issue_if.master bus
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_t;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       use_imm;
    logic       ovf_en;
    logic       inv_op2;
    logic       is_beq;
    logic       illegal;
  } dec_t;

  // Opcode/funct to ALU control; beq reuses sub but never flags overflow.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d = '0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin d.ctrl = 4'd2; d.ovf_en = 1'b1; end
          6'h22: begin d.ctrl = 4'd6; d.ovf_en = 1'b1; d.inv_op2 = 1'b1; end
          6'h24: d.ctrl = 4'd0;
          6'h25: d.ctrl = 4'd1;
          6'h2A: d.ctrl = 4'd7;
          default: d.illegal = 1'b1;
        endcase
      end
      6'h1C: begin
        if (funct == 6'h02) d.ctrl = 4'd3;
        else                d.illegal = 1'b1;
      end
      6'h08: begin d.ctrl = 4'd8; d.use_imm = 1'b1; d.ovf_en = 1'b1; end
      6'h23,
      6'h2B: begin d.ctrl = 4'd2; d.use_imm = 1'b1; d.ovf_en = 1'b1; end
      6'h04: begin d.ctrl = 4'd6; d.is_beq = 1'b1; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // Two's-complement overflow of a + b_eff giving res.
  function automatic logic signed_ovf(input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b_eff,
                                      input logic signed [DATA_W-1:0] res);
    return (a[DATA_W-1] == b_eff[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
  endfunction

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  dec_t                      pend_q;
  logic                      in_ready_q;
  logic [3:0]                alu_control_q;
  logic signed [DATA_W-1:0]  op1_q;
  logic signed [DATA_W-1:0]  op2_q;
  logic                      rsp_valid_q;
  logic [DATA_W-1:0]         rsp_result_q;
  logic                      branch_q;
  logic                      ovf_q;
  logic                      illegal_q;

  dec_t                      dec;
  logic signed [DATA_W-1:0]  imm_sext;
  logic signed [DATA_W-1:0]  op2_eff;

  assign dec      = decode(bus.in_opcode, bus.in_funct);
  assign imm_sext = {{16{bus.in_imm[15]}}, bus.in_imm};
  assign op2_eff  = pend_q.inv_op2 ? ~op2_q : op2_q;

  // Issue FSM: accept in IDLE, hold operands through DRIVE, present in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pend_q        <= '0;
      in_ready_q    <= 1'b1;
      alu_control_q <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      branch_q      <= 1'b0;
      ovf_q         <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            pend_q <= dec;
            // Illegal ops leave the ALU inputs untouched.
            if (!dec.illegal) begin
              alu_control_q <= dec.ctrl;
              op1_q         <= bus.in_rs_val;
              op2_q         <= dec.use_imm ? imm_sext : bus.in_rt_val;
            end
            cnt_q      <= CNT_W'(WAIT_CYCLES);
            in_ready_q <= 1'b0;
            state_q    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (cnt_q == CNT_W'(1)) begin
            if (pend_q.illegal) begin
              rsp_result_q <= '0;
              branch_q     <= 1'b0;
              ovf_q        <= 1'b0;
              illegal_q    <= 1'b1;
            end else begin
              rsp_result_q <= bus.alu_result;
              branch_q     <= pend_q.is_beq && (bus.alu_result == '0);
              ovf_q        <= pend_q.ovf_en && signed_ovf(op1_q, op2_eff, bus.alu_result);
              illegal_q    <= 1'b0;
            end
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready         = in_ready_q;
  assign bus.alu_control      = alu_control_q;
  assign bus.alu_operand_1    = op1_q;
  assign bus.alu_operand_2    = op2_q;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_result       = rsp_result_q;
  assign bus.rsp_branch_taken = branch_q;
  assign bus.rsp_overflow     = ovf_q;
  assign bus.rsp_illegal      = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a WAIT_CYCLES=1 instance for the
// functional vectors and a WAIT_CYCLES=3 instance for latency and mid-DRIVE reset.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic reset1;
  logic reset3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_if b1 ();
  alu_issue_if b3 ();

  // Reference combinational ALU.
  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    case (c)
      4'd0:      return a & b;
      4'd1:      return a | b;
      4'd2, 4'd8: return a + b;
      4'd3:      return a * b;
      4'd6:      return a - b;
      4'd7:      return {31'b0, ($signed(a) < $signed(b))};
      default:   return 32'h0;
    endcase
  endfunction

  assign b1.alu_result = alu_model(b1.alu_control, b1.alu_operand_1, b1.alu_operand_2);
  assign b3.alu_result = alu_model(b3.alu_control, b3.alu_operand_1, b3.alu_operand_2);

  alu_issue_ctrl #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset1), .bus(b1));
  alu_issue_ctrl #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset3), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send1(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm);
    b1.in_opcode = op; b1.in_funct = fn; b1.in_rs_val = rs; b1.in_rt_val = rt; b1.in_imm = imm;
    b1.in_valid = 1'b1;
    step();
    b1.in_valid = 1'b0;
  endtask

  task automatic send3(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt);
    b3.in_opcode = op; b3.in_funct = fn; b3.in_rs_val = rs; b3.in_rt_val = rt; b3.in_imm = 16'h0;
    b3.in_valid = 1'b1;
    step();
    b3.in_valid = 1'b0;
  endtask

  task automatic release1();
    b1.rsp_ready = 1'b1;
    step();
    b1.rsp_ready = 1'b0;
  endtask

  task automatic release3();
    b3.rsp_ready = 1'b1;
    step();
    b3.rsp_ready = 1'b0;
  endtask

  // Result/flag check for the W=1 instance one edge after accept.
  task automatic resp1(input string tag, input logic [31:0] res, input logic br,
                       input logic ov, input logic il);
    step();
    chk({tag, "_valid"}, b1.rsp_valid, 1);
    chk({tag, "_result"}, b1.rsp_result, res);
    chk({tag, "_branch"}, b1.rsp_branch_taken, br);
    chk({tag, "_ovf"}, b1.rsp_overflow, ov);
    chk({tag, "_illegal"}, b1.rsp_illegal, il);
    release1();
    chk({tag, "_ready_back"}, b1.in_ready, 1);
  endtask

  initial begin
    reset1 = 1'b1; reset3 = 1'b1;
    b1.in_valid = 1'b0; b1.rsp_ready = 1'b0; b1.in_opcode = '0; b1.in_funct = '0;
    b1.in_rs_val = '0; b1.in_rt_val = '0; b1.in_imm = '0;
    b3.in_valid = 1'b0; b3.rsp_ready = 1'b0; b3.in_opcode = '0; b3.in_funct = '0;
    b3.in_rs_val = '0; b3.in_rt_val = '0; b3.in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    reset1 = 1'b0; reset3 = 1'b0;

    chk("rst_in_ready", b1.in_ready, 1);
    chk("rst_rsp_valid", b1.rsp_valid, 0);
    chk("rst_ctrl", b1.alu_control, 0);
    chk("rst_op1", b1.alu_operand_1, 0);
    chk("rst_op2", b1.alu_operand_2, 0);
    chk("rst_result", b1.rsp_result, 0);

    // add 5+7
    send1(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
    chk("add_ctrl", b1.alu_control, 2);
    chk("add_op1", b1.alu_operand_1, 5);
    chk("add_op2", b1.alu_operand_2, 7);
    chk("add_not_yet", b1.rsp_valid, 0);
    chk("add_busy", b1.in_ready, 0);
    resp1("add", 32'd12, 0, 0, 0);

    // addi 3 + sext(0xFFFF)
    send1(6'h08, 6'h00, 32'd3, 32'h0, 16'hFFFF);
    chk("addi_ctrl", b1.alu_control, 8);
    chk("addi_op2", b1.alu_operand_2, 32'hFFFF_FFFF);
    resp1("addi", 32'd2, 0, 0, 0);

    // beq taken / not taken
    send1(6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0);
    chk("beq_ctrl", b1.alu_control, 6);
    resp1("beq_t", 32'h0, 1, 0, 0);
    send1(6'h04, 6'h00, 32'h1234, 32'h1235, 16'h0);
    resp1("beq_nt", 32'hFFFF_FFFF, 0, 0, 0);

    // signed overflow cases
    send1(6'h00, 6'h22, 32'h8000_0000, 32'd1, 16'h0);
    chk("sub_ctrl", b1.alu_control, 6);
    resp1("sub_ovf", 32'h7FFF_FFFF, 0, 1, 0);
    send1(6'h00, 6'h20, 32'h7FFF_FFFF, 32'd1, 16'h0);
    resp1("add_ovf", 32'h8000_0000, 0, 1, 0);

    // logic, slt, mul, lw
    send1(6'h00, 6'h24, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0);
    chk("and_ctrl", b1.alu_control, 0);
    resp1("and", 32'h0000_00F0, 0, 0, 0);
    send1(6'h00, 6'h25, 32'h0000_F0F0, 32'h0000_0FF0, 16'h0);
    chk("or_ctrl", b1.alu_control, 1);
    resp1("or", 32'h0000_FFF0, 0, 0, 0);
    send1(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0);
    chk("slt_ctrl", b1.alu_control, 7);
    resp1("slt", 32'd1, 0, 0, 0);
    send1(6'h1C, 6'h02, 32'd6, 32'd7, 16'h0);
    chk("mul_ctrl", b1.alu_control, 3);
    resp1("mul", 32'd42, 0, 0, 0);
    send1(6'h23, 6'h00, 32'h100, 32'h0, 16'hFFFC);
    chk("lw_ctrl", b1.alu_control, 2);
    chk("lw_op2", b1.alu_operand_2, 32'hFFFF_FFFC);
    resp1("lw", 32'h0000_00FC, 0, 0, 0);

    // backpressure: response held, extra request ignored
    send1(6'h00, 6'h20, 32'd1, 32'd2, 16'h0);
    step();
    b1.in_opcode = 6'h00; b1.in_funct = 6'h22; b1.in_rs_val = 32'd50; b1.in_rt_val = 32'd9;
    b1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", b1.rsp_valid, 1);
      chk("bp_result", b1.rsp_result, 3);
      chk("bp_in_ready", b1.in_ready, 0);
      chk("bp_ctrl_held", b1.alu_control, 2);
    end
    b1.in_valid = 1'b0;
    release1();
    step();
    chk("bp_dropped_idle", b1.in_ready, 1);
    chk("bp_dropped_novalid", b1.rsp_valid, 0);

    // illegal opcode: ALU inputs untouched, only illegal flag set
    send1(6'h3F, 6'h00, 32'hAAAA, 32'hBBBB, 16'h0);
    chk("ill_ctrl_kept", b1.alu_control, 2);
    chk("ill_op1_kept", b1.alu_operand_1, 1);
    chk("ill_op2_kept", b1.alu_operand_2, 2);
    resp1("ill", 32'h0, 0, 0, 1);
    send1(6'h00, 6'h20, 32'd10, 32'd20, 16'h0);
    resp1("post_ill", 32'd30, 0, 0, 0);

    // WAIT_CYCLES=3 latency
    send3(6'h00, 6'h20, 32'd5, 32'd7);
    step();
    chk("w3_e1", b3.rsp_valid, 0);
    step();
    chk("w3_e2", b3.rsp_valid, 0);
    step();
    chk("w3_e3", b3.rsp_valid, 1);
    chk("w3_result", b3.rsp_result, 12);
    release3();

    // reset in the middle of DRIVE drops the op
    send3(6'h00, 6'h22, 32'd9, 32'd4);
    chk("w3_sub_ctrl", b3.alu_control, 6);
    step();
    reset3 = 1'b1;
    step();
    reset3 = 1'b0;
    chk("mid_rst_in_ready", b3.in_ready, 1);
    chk("mid_rst_valid", b3.rsp_valid, 0);
    chk("mid_rst_ctrl", b3.alu_control, 0);
    chk("mid_rst_op1", b3.alu_operand_1, 0);
    chk("mid_rst_op2", b3.alu_operand_2, 0);
    chk("mid_rst_result", b3.rsp_result, 0);
    repeat (4) step();
    chk("mid_rst_no_resp", b3.rsp_valid, 0);
    send3(6'h00, 6'h20, 32'd2, 32'd2);
    repeat (3) step();
    chk("w3_recover_valid", b3.rsp_valid, 1);
    chk("w3_recover_result", b3.rsp_result, 4);
    release3();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
